// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: two-requester arbiter driving a registered 2:1 mux with bounded hold under contention
module mux_select_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              X,
  output logic [DATA_W-1:0] out1,
  output logic              out_valid
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam logic [3:0] HMAX = 4'(MAX_HOLD);
  state_t r_state, w_next;
  logic [3:0] r_hold, w_hold;
  logic r_last_b, r_x, w_sat;
  assign w_sat = r_hold == HMAX;
  assign gnt_a = r_state == OWN_A;
  assign gnt_b = r_state == OWN_B;
  assign X     = r_x;
  // next owner: ties go opposite the last owner, a saturated hold yields to a waiting rival
  always_comb begin
    w_next = r_state == IDLE  ? (req_a && req_b ? (r_last_b ? OWN_A : OWN_B) :
                                 req_a ? OWN_A : req_b ? OWN_B : IDLE) :
             r_state == OWN_A ? (!req_a ? (req_b ? OWN_B : IDLE) :
                                 (req_b && w_sat) ? OWN_B : OWN_A) :
             r_state == OWN_B ? (!req_b ? (req_a ? OWN_A : IDLE) :
                                 (req_a && w_sat) ? OWN_A : OWN_B) : IDLE;
    w_hold = w_next == IDLE ? 4'd0 : w_next != r_state ? 4'd1 : w_sat ? r_hold : r_hold + 4'd1;
  end
  // state, hold count, ownership memory, select and data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hold    <= 4'd0;
      r_last_b  <= 1'b1;
      r_x       <= 1'b0;
      out1      <= '0;
      out_valid <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_hold    <= w_hold;
      if (w_next != r_state && w_next != IDLE) r_last_b <= w_next == OWN_B;
      r_x       <= w_next == OWN_A ? 1'b0 : w_next == OWN_B ? 1'b1 : r_x;
      out_valid <= r_state != IDLE;
      if (r_state != IDLE) out1 <= r_x ? B : A;
    end
  end
endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb_mux_select_arbiter: randomized and directed checks of two arbiter instances against an ownership model
module tb_mux_select_arbiter;
  logic clk = 1'b0, rst, req_a, req_b;
  logic [7:0] A, B, o4, o1;
  logic [1:0] ga, gb, xx, ov;
  int n_chk = 0, n_fail = 0;
  int m_own [2], m_run [2], m_last [2], mh [2];
  logic m_x [2], m_ov [2];
  logic [7:0] m_out [2];

  always #5 clk = ~clk;

  mux_select_arbiter #(.DATA_W(8), .MAX_HOLD(4)) u4 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .A(A), .B(B),
    .gnt_a(ga[0]), .gnt_b(gb[0]), .X(xx[0]), .out1(o4), .out_valid(ov[0]));
  mux_select_arbiter #(.DATA_W(8), .MAX_HOLD(1)) u1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .A(A), .B(B),
    .gnt_a(ga[1]), .gnt_b(gb[1]), .X(xx[1]), .out1(o1), .out_valid(ov[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model(input int k);
    int nw;
    if (rst) begin
      m_own[k] = 0; m_run[k] = 0; m_last[k] = 2; m_x[k] = 1'b0; m_out[k] = 8'h00; m_ov[k] = 1'b0;
      return;
    end
    m_ov[k] = m_own[k] != 0;
    if (m_own[k] != 0) m_out[k] = (m_own[k] == 1) ? A : B;
    if (m_own[k] == 0)      nw = (req_a && req_b) ? 3 - m_last[k] : req_a ? 1 : req_b ? 2 : 0;
    else if (m_own[k] == 1) nw = !req_a ? (req_b ? 2 : 0) : (req_b && m_run[k] >= mh[k]) ? 2 : 1;
    else                    nw = !req_b ? (req_a ? 1 : 0) : (req_a && m_run[k] >= mh[k]) ? 1 : 2;
    if (nw == 0) m_run[k] = 0;
    else if (nw != m_own[k]) begin m_run[k] = 1; m_last[k] = nw; end
    else m_run[k] = m_run[k] + 1;
    if (nw != 0) m_x[k] = nw == 2;
    m_own[k] = nw;
  endtask

  task automatic step(input logic r, input logic ra, input logic rb, input logic [7:0] a, input logic [7:0] b);
    rst = r; req_a = ra; req_b = rb; A = a; B = b;
    @(posedge clk);
    model(0); model(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("gnt_a", ga[k], m_own[k] == 1);
      chk("gnt_b", gb[k], m_own[k] == 2);
      chk("X", xx[k], m_x[k]);
      chk("out1", k == 0 ? o4 : o1, m_out[k]);
      chk("out_valid", ov[k], m_ov[k]);
      chk("one_hot", ga[k] & gb[k], 1'b0);
    end
  endtask

  initial begin
    mh[0] = 4; mh[1] = 1;
    step(1, 1, 1, 8'h55, 8'h66);
    step(1, 0, 0, 8'h00, 8'h00);
    chk("rst_out1", o4, 8'h00);
    chk("rst_x", xx[0], 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 8'h11, 8'h22);
      chk("tie4_gnt_a", ga[0], ((i / 4) % 2) == 0);
      chk("tie4_x", xx[0], ((i / 4) % 2) == 1);
      if (i < 6) chk("tie1_gnt_a", ga[1], (i % 2) == 0);
      if (i >= 1 && i < 7) chk("tie1_out1", o1, ((i - 1) % 2 == 0) ? 8'h11 : 8'h22);
    end
    step(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'h3C, 8'h00);
      chk("solo_gnt_a", ga[0], 1'b1);
      if (i > 0) chk("solo_out1", o4, 8'h3C);
    end
    step(0, 0, 0, 8'h3C, 8'h00);
    chk("solo_drop_gnt", ga[0], 1'b0);
    chk("solo_last_out1", o4, 8'h3C);
    chk("solo_last_valid", ov[0], 1'b1);
    step(0, 0, 0, 8'h00, 8'h00);
    chk("solo_idle_valid", ov[0], 1'b0);
    chk("solo_hold_out1", o4, 8'h3C);
    step(0, 1, 0, 8'h77, 8'h00);
    step(0, 0, 1, 8'h77, 8'hA5);
    chk("hand_gnt_b", gb[0], 1'b1);
    chk("hand_x", xx[0], 1'b1);
    chk("hand_valid", ov[0], 1'b1);
    step(0, 0, 1, 8'h77, 8'hA5);
    chk("hand_out1", o4, 8'hA5);
    chk("hand_valid2", ov[0], 1'b1);
    step(1, 1, 1, 8'h12, 8'h34);
    chk("midrst_gnt_b", gb[0], 1'b0);
    chk("midrst_valid", ov[0], 1'b0);
    chk("midrst_out1", o4, 8'h00);
    step(0, 1, 1, 8'h12, 8'h34);
    chk("midrst_first_a", ga[0], 1'b1);
    step(1, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h44);
    step(0, 0, 1, 8'h00, 8'h44);
    step(0, 0, 0, 8'h00, 8'h00);
    chk("bidle_gnt", ga[0] | gb[0], 1'b0);
    step(0, 1, 1, 8'h00, 8'h00);
    chk("tie_after_b", ga[0], 1'b1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
